// File: rtl/game_timer_pkg.sv
// game_timer_pkg
//   Shared types and helpers for the BCD countdown timer.
//   - timer_state_t : controller states (IDLE, RUN, PAUSED, EXPIRED)
//   - bcd_t         : one BCD digit
//   - to_bcd        : constant conversion of a binary value to packed BCD
//                     (up to 8 digits, digit 0 in [3:0])
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned BCD_MAX_DIGITS = 8;
  localparam int unsigned BONUS_SAT      = 255;

  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [4*BCD_MAX_DIGITS-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_timer_digit.sv
// bcd_digit
//   One registered BCD digit of the timer count. Digits are chained:
//   a digit steps up when inc and carry_in are both high, and steps down
//   when dec and borrow_in are both high. carry_out/borrow_out ripple to
//   the next more significant digit.
// Ports:
//   clk        in  clock
//   load       in  synchronous load of load_val (highest priority)
//   load_val   in  value loaded on load
//   inc, dec   in  count-wide increment / decrement enables
//   carry_in   in  increment reaches this digit
//   borrow_in  in  decrement reaches this digit
//   digit      out current digit value
//   carry_out  out carry_in and this digit is 9
//   borrow_out out borrow_in and this digit is 0
//   wrap       out this digit wraps (9->0 or 0->9) on the coming edge
module bcd_digit
  import game_timer_pkg::*;
(
  input  logic clk,
  input  logic load,
  input  bcd_t load_val,
  input  logic inc,
  input  logic dec,
  input  logic carry_in,
  input  logic borrow_in,
  output bcd_t digit,
  output logic carry_out,
  output logic borrow_out,
  output logic wrap
);

  logic step_up;
  logic step_dn;
  logic is_nine;
  logic is_zero;

  assign is_nine    = (digit == 4'd9);
  assign is_zero    = (digit == 4'd0);
  assign step_up    = inc && carry_in;
  assign step_dn    = dec && borrow_in;
  assign carry_out  = carry_in && is_nine;
  assign borrow_out = borrow_in && is_zero;
  assign wrap       = (step_up && is_nine) || (step_dn && is_zero);

  always_ff @(posedge clk) begin
    if (load) begin
      digit <= load_val;
    end else if (step_up) begin
      digit <= is_nine ? 4'd0 : digit + 4'd1;
    end else if (step_dn) begin
      digit <= is_zero ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// game_timer
//   BCD countdown timer clocked by the video frame clock. Counts
//   START_VALUE down to zero once per second, supports pause and a
//   time-bonus add, and flags expiry.
//   Optional feature macro: TIMER_BONUS_EN (bonus path present when defined;
//   otherwise bonus_add is ignored and the count only decrements).
// Ports:
//   frame_clk     in   clock, one cycle per frame
//   Reset         in   synchronous active-high reset
//   game_restart  in   synchronous return to IDLE, count reloaded
//   start         in   begin counting from IDLE
//   pause         in   level, freezes counting while high
//   bonus_add     in   one-cycle request to add BONUS_SECS
//   digits_bcd    out  count as BCD, digit 0 (ones) in [3:0]
//   running       out  high in RUN
//   expired       out  high in EXPIRED
//   timeout_pulse out  one-cycle pulse, first cycle in EXPIRED
//   warn          out  count <= WARN_SECS while in RUN or PAUSED
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned START_VALUE    = 30,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned WARN_SECS      = 5,
  parameter int unsigned BONUS_SECS     = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    game_restart,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    bonus_add,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic                    running,
  output logic                    expired,
  output logic                    timeout_pulse,
  output logic                    warn
);

  localparam int unsigned CW        = 4 * NUM_DIGITS;
  localparam int unsigned MAX_COUNT = 10**NUM_DIGITS - 1;
  localparam int unsigned WARN_CLMP = (WARN_SECS > MAX_COUNT) ? MAX_COUNT : WARN_SECS;
  localparam int unsigned DIV_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  localparam logic [4*BCD_MAX_DIGITS-1:0] START_FULL = to_bcd(START_VALUE);
  localparam logic [4*BCD_MAX_DIGITS-1:0] WARN_FULL  = to_bcd(WARN_CLMP);
  localparam logic [CW-1:0]    START_BCD = START_FULL[CW-1:0];
  localparam logic [CW-1:0]    WARN_BCD  = WARN_FULL[CW-1:0];
  localparam logic [CW-1:0]    ONE_BCD   = CW'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAMES_PER_SEC - 1);

  timer_state_t state;
  timer_state_t state_next;

  logic [DIV_W-1:0]    divider;
  logic [CW-1:0]       count;
  logic [NUM_DIGITS:0] carry_chain;
  logic [NUM_DIGITS:0] borrow_chain;
  logic [NUM_DIGITS-1:0] wrap_unused;

  logic active;
  logic sec_tick;
  logic inc_req;
  logic do_inc;
  logic do_dec;
  logic at_max;
  logic is_zero;
  logic expire;
  logic load_count;
  logic pulse_q;

  assign active   = (state == RUN) || (state == PAUSED);
  assign sec_tick = (state == RUN) && (divider == DIV_LAST);

  // Chains are seeded at digit 0, so the top-digit outputs report
  // "all nines" and "all zeros" for the whole count.
  assign carry_chain[0]  = 1'b1;
  assign borrow_chain[0] = 1'b1;
  assign at_max          = carry_chain[NUM_DIGITS];
  assign is_zero         = borrow_chain[NUM_DIGITS];

  // An increment coinciding with a second tick cancels both; the pending
  // bonus still drains. Increments at all-nines are dropped.
  assign do_inc = inc_req && !sec_tick && !at_max;
  assign do_dec = sec_tick && !inc_req && !is_zero;
  assign expire = sec_tick && !inc_req && (is_zero || (count == ONE_BCD));

  assign load_count = Reset || game_restart;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (frame_clk),
      .load       (load_count),
      .load_val   (START_BCD[4*i +: 4]),
      .inc        (do_inc),
      .dec        (do_dec),
      .carry_in   (carry_chain[i]),
      .borrow_in  (borrow_chain[i]),
      .digit      (count[4*i +: 4]),
      .carry_out  (carry_chain[i+1]),
      .borrow_out (borrow_chain[i+1]),
      .wrap       (wrap_unused[i])
    );
  end

`ifdef TIMER_BONUS_EN
  logic [7:0] bonus_pending;
  logic [8:0] bonus_sum;
  logic [7:0] bonus_next;

  always_comb begin
    bonus_sum = {1'b0, bonus_pending};
    if (bonus_pending != 8'd0) begin
      bonus_sum = bonus_sum - 9'd1;
    end
    if (bonus_add) begin
      bonus_sum = bonus_sum + 9'(BONUS_SECS);
    end
    bonus_next = (bonus_sum > 9'(BONUS_SAT)) ? 8'(BONUS_SAT) : bonus_sum[7:0];
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || game_restart || expire) begin
      bonus_pending <= '0;
    end else if (active) begin
      bonus_pending <= bonus_next;
    end
  end

  assign inc_req = active && (bonus_pending != 8'd0);
`else
  logic [8:0] unused_bonus;
  assign unused_bonus = {bonus_add, 8'(BONUS_SECS)};
  assign inc_req      = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (game_restart) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_next = RUN;
        RUN: begin
          if (expire)     state_next = EXPIRED;
          else if (pause) state_next = PAUSED;
        end
        PAUSED:  if (!pause) state_next = RUN;
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Divider only advances in RUN; PAUSED keeps it so the partial second
  // resumes where it left off.
  always_ff @(posedge frame_clk) begin
    if (Reset || game_restart) begin
      divider <= '0;
    end else if (state == RUN) begin
      divider <= sec_tick ? '0 : divider + 1'b1;
    end else if (state == IDLE) begin
      divider <= '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || game_restart) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= expire;
    end
  end

  // BCD packed vectors order the same as their decimal values.
  assign digits_bcd    = count;
  assign running       = (state == RUN);
  assign expired       = (state == EXPIRED);
  assign timeout_pulse = pulse_q;
  assign warn          = active && (count <= WARN_BCD);

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;
  import game_timer_pkg::*;

`ifdef TIMER_BONUS_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       game_restart = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       bonus_add = 1'b0;
  logic [7:0] digits_bcd;
  logic       running;
  logic       expired;
  logic       timeout_pulse;
  logic       warn;

  game_timer #(
    .NUM_DIGITS     (2),
    .START_VALUE    (12),
    .FRAMES_PER_SEC (4),
    .WARN_SECS      (5),
    .BONUS_SECS     (3)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .game_restart  (game_restart),
    .start         (start),
    .pause         (pause),
    .bonus_add     (bonus_add),
    .digits_bcd    (digits_bcd),
    .running       (running),
    .expired       (expired),
    .timeout_pulse (timeout_pulse),
    .warn          (warn)
  );

  always #5 frame_clk = ~frame_clk;

  int unsigned cyc = 0;
  always @(posedge frame_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [11:0] exp;
  } chk_t;

  chk_t        sb[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned pulse_cnt  = 0;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] d, input logic r,
                     input logic e, input logic w, input logic p);
    chk_t c;
    c.cyc  = cyc;
    c.name = name;
    c.exp  = {d, r, e, w, p};
    sb.push_back(c);
  endtask

  // Monitor: DUT state is presented every cycle; compare whatever the
  // stimulus queued for this cycle.
  initial begin
    chk_t        c;
    logic [11:0] act;
    forever begin
      @(negedge frame_clk);
      if (timeout_pulse === 1'b1) pulse_cnt++;
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        c   = sb.pop_front();
        act = {digits_bcd, running, expired, warn, timeout_pulse};
        compared++;
        if (act !== c.exp) begin
          mismatched++;
          $display("FAIL %s: got digits=%h run=%b exp=%b warn=%b pulse=%b, want digits=%h run=%b exp=%b warn=%b pulse=%b",
                   c.name, act[11:4], act[3], act[2], act[1], act[0],
                   c.exp[11:4], c.exp[3], c.exp[2], c.exp[1], c.exp[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    step(2);
    Reset = 1'b0;
    chk("reset", 8'h12, 0, 0, 0, 0);
    step(1); chk("idle_hold", 8'h12, 0, 0, 0, 0);

    start = 1'b1; step(1); start = 1'b0;
    chk("start", 8'h12, 1, 0, 0, 0);
    step(3); chk("pre_tick",  8'h12, 1, 0, 0, 0);
    step(1); chk("first_dec", 8'h11, 1, 0, 0, 0);
    step(4); chk("dec_10",    8'h10, 1, 0, 0, 0);
    step(4); chk("borrow_09", 8'h09, 1, 0, 0, 0);
    step(4); chk("dec_08",    8'h08, 1, 0, 0, 0);

    // pause with divider at 2
    step(2);
    pause = 1'b1; step(1); chk("pause_enter", 8'h08, 0, 0, 0, 0);
    step(9); chk("pause_hold", 8'h08, 0, 0, 0, 0);
    pause = 1'b0; step(1); chk("pause_release", 8'h08, 1, 0, 0, 0);
    step(1); chk("resume_dec", 8'h07, 1, 0, 0, 0);

    // warn threshold and bonus lifting the count out of it
    step(4); chk("dec_06", 8'h06, 1, 0, 0, 0);
    step(3);
    bonus_add = 1'b1; step(1); bonus_add = 1'b0;
    chk("warn_on", 8'h05, 1, 0, 1, 0);
    step(1); chk("warn_bonus1", BON ? 8'h06 : 8'h05, 1, 0, !BON, 0);
    step(1); chk("warn_bonus2", BON ? 8'h07 : 8'h05, 1, 0, !BON, 0);
    step(1); chk("warn_bonus3", BON ? 8'h08 : 8'h05, 1, 0, !BON, 0);
    step(1); chk("warn_tick",   BON ? 8'h07 : 8'h04, 1, 0, !BON, 0);
    game_restart = 1'b1; step(1); game_restart = 1'b0;
    chk("restart_run", 8'h12, 0, 0, 0, 0);

    // run to expiry
    start = 1'b1; step(1); start = 1'b0;
    chk("start2", 8'h12, 1, 0, 0, 0);
    step(8);  chk("count_10",     8'h10, 1, 0, 0, 0);
    step(4);  chk("borrow_10_09", 8'h09, 1, 0, 0, 0);
    step(32); chk("count_01",     8'h01, 1, 0, 1, 0);
    step(3);  chk("count_01_hold", 8'h01, 1, 0, 1, 0);
    step(1);  chk("expire",       8'h00, 0, 1, 0, 1);
    step(1);  chk("pulse_clear",  8'h00, 0, 1, 0, 0);
    start = 1'b1; bonus_add = 1'b1; step(1); start = 1'b0; bonus_add = 1'b0;
    chk("expired_ignores", 8'h00, 0, 1, 0, 0);
    step(17); chk("expired_hold", 8'h00, 0, 1, 0, 0);
    game_restart = 1'b1; step(1); game_restart = 1'b0;
    chk("restart_expired", 8'h12, 0, 0, 0, 0);

    // bonus from 08, then a bonus whose second increment meets a tick
    start = 1'b1; step(1); start = 1'b0;
    chk("start3", 8'h12, 1, 0, 0, 0);
    step(15); chk("count_09", 8'h09, 1, 0, 0, 0);
    bonus_add = 1'b1; step(1); bonus_add = 1'b0;
    chk("bonus_at_08", 8'h08, 1, 0, 0, 0);
    step(1); chk("bon_09",   BON ? 8'h09 : 8'h08, 1, 0, 0, 0);
    step(1); chk("bon_10",   BON ? 8'h10 : 8'h08, 1, 0, 0, 0);
    step(1); chk("bon_11",   BON ? 8'h11 : 8'h08, 1, 0, 0, 0);
    step(1); chk("bon_tick", BON ? 8'h10 : 8'h07, 1, 0, 0, 0);
    step(1); chk("pre_coincide", BON ? 8'h10 : 8'h07, 1, 0, 0, 0);
    bonus_add = 1'b1; step(1); bonus_add = 1'b0;
    chk("coincide_req",   BON ? 8'h10 : 8'h07, 1, 0, 0, 0);
    step(1); chk("coincide_inc1",  BON ? 8'h11 : 8'h07, 1, 0, 0, 0);
    step(1); chk("coincide_hold",  BON ? 8'h11 : 8'h06, 1, 0, 0, 0);
    step(1); chk("coincide_final", BON ? 8'h12 : 8'h06, 1, 0, 0, 0);

    // restart mid-bonus discards the pending seconds
    bonus_add = 1'b1; step(1); bonus_add = 1'b0;
    chk("midbonus_req", BON ? 8'h12 : 8'h06, 1, 0, 0, 0);
    step(1); chk("midbonus_inc", BON ? 8'h13 : 8'h06, 1, 0, 0, 0);
    game_restart = 1'b1; step(1); game_restart = 1'b0;
    chk("restart_midbonus", 8'h12, 0, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    chk("start4", 8'h12, 1, 0, 0, 0);
    step(3); chk("no_stale_bonus",    8'h12, 1, 0, 0, 0);
    step(1); chk("dec_after_restart", 8'h11, 1, 0, 0, 0);

    // bonus while paused, driven into the all-nines clamp
    pause = 1'b1; bonus_add = 1'b1; step(1);
    chk("pause_bonus", 8'h11, 0, 0, 0, 0);
    step(29); chk("paused_incs", BON ? 8'h40 : 8'h11, 0, 0, 0, 0);
    bonus_add = 1'b0;
    step(70); chk("max_clamp", BON ? 8'h99 : 8'h11, 0, 0, 0, 0);
    game_restart = 1'b1; pause = 1'b0; step(1); game_restart = 1'b0;
    chk("restart_final", 8'h12, 0, 0, 0, 0);

    step(2);
    compared++;
    if (pulse_cnt != 1) begin
      mismatched++;
      $display("FAIL pulse_count: got %0d timeout pulses, want 1", pulse_cnt);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
